// File: rtl/lock_pkg.sv
// Shared types and defaults for the serial combination lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4,
    PROGRAM = 3'd5
  } state_t;

  localparam int CODE_LEN_DEF    = 4;
  localparam int MAX_FAIL_DEF    = 3;
  localparam int OPEN_CYC_DEF    = 8;
  localparam int LOCKOUT_CYC_DEF = 16;

  localparam logic [3:0] DEFAULT_CODE_DEF = 4'b0111;

  function automatic int tmr_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  localparam int TMR_W_DEF = tmr_w(OPEN_CYC_DEF, LOCKOUT_CYC_DEF);

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done while the count sits at 1, holds at 0.
module lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/lock_controller.sv
// Serial combination lock: code entry, timed unlock window,
// failure counting with timed lockout, and code re-programming.
module lock_controller
  import lock_pkg::*;
#(
  parameter int CODE_LEN    = CODE_LEN_DEF,
  parameter int MAX_FAIL    = MAX_FAIL_DEF,
  parameter int OPEN_CYC    = OPEN_CYC_DEF,
  parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE = DEFAULT_CODE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic cancel,
  input  logic prog_req,
  output logic unlock,
  output logic lockout,
  output logic prog_mode,
  output logic fail_pulse,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int TW = tmr_w(OPEN_CYC, LOCKOUT_CYC);

  state_t              state_q, state_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]       fail_cnt_q, fail_cnt_d;
  logic                unlock_q, unlock_d;
  logic                lockout_q, lockout_d;
  logic                prog_mode_q, prog_mode_d;
  logic                fail_pulse_q, fail_pulse_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_done;

  logic [CODE_LEN-1:0] shift_nxt;
  logic                last_bit;
  logic [FW-1:0]       fail_inc;

  assign shift_nxt = {shift_q[CODE_LEN-2:0], bit_in};
  assign last_bit  = (bit_cnt_q == CW'(CODE_LEN - 1));
  assign fail_inc  = (fail_cnt_q == FW'(MAX_FAIL)) ? fail_cnt_q
                                                   : fail_cnt_q + 1'b1;

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    fail_pulse_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    case (state_q)
      IDLE: begin
        if (bit_valid) begin
          shift_d   = shift_nxt;
          bit_cnt_d = CW'(1);
          state_d   = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (bit_valid) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        bit_cnt_d = '0;
        if (shift_q == code_q) begin
          fail_cnt_d = '0;
          tmr_load   = 1'b1;
          tmr_val    = TW'(OPEN_CYC);
          state_d    = OPEN;
        end else begin
          fail_pulse_d = 1'b1;
          fail_cnt_d   = fail_inc;
          if (fail_inc == FW'(MAX_FAIL)) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(LOCKOUT_CYC);
            state_d  = LOCKOUT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OPEN: begin
        if (cancel || tmr_done) begin
          state_d = IDLE;
        end else if (prog_req) begin
          bit_cnt_d = '0;
          state_d   = PROGRAM;
        end
      end
      LOCKOUT: begin
        if (tmr_done) begin
          fail_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      PROGRAM: begin
        if (cancel) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else if (bit_valid) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            code_d     = shift_nxt;
            bit_cnt_d  = '0;
            fail_cnt_d = '0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Window flags lag the state by one edge; an abort in OPEN clears unlock on the next edge.
  always_comb begin
    unlock_d    = (state_q == OPEN) && !cancel && !prog_req;
    lockout_d   = (state_q == LOCKOUT);
    prog_mode_d = (state_q == PROGRAM) && (state_d == PROGRAM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      code_q       <= DEFAULT_CODE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      unlock_q     <= 1'b0;
      lockout_q    <= 1'b0;
      prog_mode_q  <= 1'b0;
      fail_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      unlock_q     <= unlock_d;
      lockout_q    <= lockout_d;
      prog_mode_q  <= prog_mode_d;
      fail_pulse_q <= fail_pulse_d;
    end
  end

  assign unlock     = unlock_q;
  assign lockout    = lockout_q;
  assign prog_mode  = prog_mode_q;
  assign fail_pulse = fail_pulse_q;
  assign fail_cnt   = fail_cnt_q;

endmodule

// File: doc/lock_controller.md
Name: lock_controller

Overview:
Sequencing controller for the serial combination lock: accepts code bits one per valid strobe, compares against a programmable stored code, and drives a timed unlock window. Counts consecutive failures and imposes a timed lockout; supports code re-programming only while unlocked. Sits between the keypad/serial front end and the door actuator.

Parameters:
CODE_LEN, 4, number of bits per code entry (>=2)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
OPEN_CYC, 8, cycles unlock stays high
LOCKOUT_CYC, 16, cycles lockout stays high
DEFAULT_CODE, 4'b0111, code loaded at reset (CODE_LEN bits)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
bit_valid  in  1  bit_in is valid this cycle
bit_in  in  1  code bit, MSB first
cancel  in  1  abort current entry/programming/open window
prog_req  in  1  enter programming mode (honoured only in OPEN)
unlock  out  1  lock open
lockout  out  1  lockout active, input ignored
prog_mode  out  1  programming new code
fail_pulse  out  1  one-cycle pulse per failed attempt
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Reset (reset==0, async): state IDLE, code_reg=DEFAULT_CODE, shift_reg=0, bit_cnt=0, fail_cnt=0, timer=0; all outputs 0. Programmed code is lost.
- All outputs registered/state-decoded; no combinational path input->output.
- Shift rule: on accepted bit, shift_reg <= {shift_reg[CODE_LEN-2:0], bit_in}; bit_cnt++.
- IDLE: bit_valid -> shift, bit_cnt=1, go ENTRY. cancel/prog_req ignored.
- ENTRY: bit_valid shifts; when the CODE_LEN-th bit is accepted go CHECK. Idle gaps between bits allowed, no timeout. cancel -> IDLE, entry discarded, fail_cnt unchanged; cancel wins over simultaneous bit_valid.
- CHECK (exactly 1 cycle, bit_valid ignored): match -> OPEN, fail_cnt=0, timer=OPEN_CYC. Mismatch -> fail_pulse=1 next cycle, fail_cnt++; if new fail_cnt==MAX_FAIL -> LOCKOUT, timer=LOCKOUT_CYC, else IDLE.
- Latency: last bit sampled at edge N; CHECK during cycle N..N+1; unlock/lockout high after edge N+2.
- OPEN: unlock=1 for exactly OPEN_CYC cycles, then IDLE. cancel -> IDLE immediately. prog_req -> PROGRAM (unlock drops next edge); prog_req and cancel together: cancel wins. bit_valid ignored.
- LOCKOUT: lockout=1 for exactly LOCKOUT_CYC cycles; bit_valid, cancel, prog_req ignored. On expiry -> IDLE, fail_cnt=0.
- PROGRAM: prog_mode=1; CODE_LEN accepted bits shift in; on last bit code_reg <= new value (including that bit), fail_cnt=0, go IDLE. cancel -> IDLE, code_reg unchanged.
- Timer: loaded on state entry, decrements each cycle, exit when reaching 1; no wrap.
- fail_cnt saturates at MAX_FAIL; never wraps.
- Any unmapped state -> IDLE.

Decomposition:
- Package lock_pkg: state_t enum (IDLE, ENTRY, CHECK, OPEN, LOCKOUT, PROGRAM), default parameter constants, timer width localparam.
- One sub-module lock_timer: loadable down-counter with done flag, shared by OPEN and LOCKOUT.

Test Plan:
- Reset, bits 0,1,1,1 -> unlock high 2 edges after 4th bit, exactly 8 cycles; fail_cnt=0.
- Three entries of 1,1,1,1 -> fail_pulse x3, fail_cnt 1,2,3, lockout high 16 cycles; bits during lockout ignored; afterwards fail_cnt=0 and 0,1,1,1 unlocks.
- Unlock, prog_req, bits 1,0,1,0 -> code 1010; 0,1,1,1 then fails (fail_cnt=1); 1,0,1,0 unlocks, fail_cnt=0.
- Entry 0,1 then cancel -> IDLE, fail_cnt unchanged; then 0,1,1,1 with 3-cycle gaps between bits -> unlock.
- Assert reset mid-OPEN after programming 1010 -> unlock=0 without clock edge; after release 0,1,1,1 unlocks, 1,0,1,0 fails.
- cancel and prog_req together in OPEN -> IDLE, prog_mode stays 0, code unchanged.
